// File: rtl/r5p_hpm_pkg.sv
// rtl/r5p_hpm_pkg.sv - shared HPM CSR addresses, register layouts and address decode
package r5p_hpm_pkg;

  localparam logic [11:0] CSR_MHPMCOUNTER   = 12'hB00;
  localparam logic [11:0] CSR_MHPMCOUNTERH  = 12'hB80;
  localparam logic [11:0] CSR_HPMCOUNTER    = 12'hC00;
  localparam logic [11:0] CSR_HPMCOUNTERH   = 12'hC80;
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;

  localparam int HPM_NUM    = 32;
  localparam int HPM_EW_MAX = 63;

  typedef enum logic [1:0] {
    HPM_KIND_CNT,
    HPM_KIND_INH,
    HPM_KIND_EVT
  } hpm_kind_t;

  typedef struct packed {
    logic [28:0] hpm;
    logic        ir;
    logic        tm;
    logic        cy;
  } r5p_hpm_inhibit_t;

  typedef struct packed {
    logic                  of;
    logic [HPM_EW_MAX-1:0] mask;
  } r5p_hpmevent_cfg_t;

  typedef struct packed {
    logic      hit;
    logic [4:0] idx;
    logic      hi;
    logic      mirror;
    hpm_kind_t kind;
  } hpm_dec_t;

  // Index 1 (time) is never decoded here; high halves only exist on a 32-bit port.
  function automatic hpm_dec_t hpm_decode(input logic [11:0] adr, input logic split);
    hpm_dec_t d;
    d      = '0;
    d.idx  = adr[4:0];
    d.kind = HPM_KIND_CNT;
    if (adr[11:5] == CSR_MHPMCOUNTER[11:5]) begin
      d.hit = (adr[4:0] != 5'd1);
    end else if (adr[11:5] == CSR_MHPMCOUNTERH[11:5]) begin
      d.hit = split && (adr[4:0] != 5'd1);
      d.hi  = 1'b1;
    end else if (adr[11:5] == CSR_HPMCOUNTER[11:5]) begin
      d.hit    = (adr[4:0] != 5'd1);
      d.mirror = 1'b1;
    end else if (adr[11:5] == CSR_HPMCOUNTERH[11:5]) begin
      d.hit    = split && (adr[4:0] != 5'd1);
      d.hi     = 1'b1;
      d.mirror = 1'b1;
    end else if (adr[11:5] == CSR_MCOUNTINHIBIT[11:5]) begin
      if (adr[4:0] == 5'd0) begin
        d.hit  = 1'b1;
        d.kind = HPM_KIND_INH;
      end else if (adr[4:0] >= 5'd3) begin
        d.hit  = 1'b1;
        d.kind = HPM_KIND_EVT;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/r5p_hpm_if.sv
// rtl/r5p_hpm_if.sv - CSR access port between the CSR file and the HPM bank
interface r5p_hpm_if #(
  parameter int XLEN = 32
);

  logic            en;
  logic            we;
  logic [11:0]     adr;
  logic [XLEN-1:0] wdt;
  logic [XLEN-1:0] rdt;
  logic            hit;
  logic            ill;

  modport master (output en, we, adr, wdt, input rdt, hit, ill);
  modport slave  (input en, we, adr, wdt, output rdt, hit, ill);

endinterface

// File: rtl/r5p_hpm_cnt.sv
// rtl/r5p_hpm_cnt.sv - one CW-bit event counter with split CSR write and sticky overflow flag
module r5p_hpm_cnt #(
  parameter int XLEN   = 32,
  parameter int CW     = 64,
  parameter bit OVF_EN = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inc,
  input  logic            wr_lo,
  input  logic            wr_hi,
  input  logic [XLEN-1:0] wdt,
  input  logic            of_wr,
  input  logic            of_wdt,
  output logic [CW-1:0]   cnt,
  output logic            of
);

  logic          wr;
  logic          wrap;
  logic [CW-1:0] cnt_nxt;

  assign wr   = wr_lo | wr_hi;
  assign wrap = inc & ~wr & (&cnt);

  // A CSR write replaces its half and suppresses this cycle's increment.
  if (CW > XLEN) begin : g_split
    always_comb begin
      cnt_nxt = cnt + CW'(inc);
      if (wr_lo) cnt_nxt = {cnt[CW-1:XLEN], wdt};
      if (wr_hi) cnt_nxt = {wdt[CW-XLEN-1:0], cnt[XLEN-1:0]};
    end
  end else begin : g_flat
    always_comb begin
      cnt_nxt = cnt + CW'(inc);
      if (wr) cnt_nxt = wdt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt_nxt;
  end

  // A wrap on the same edge as a clearing write keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      of <= 1'b0;
    end else if (OVF_EN) begin
      if (wrap)       of <= 1'b1;
      else if (of_wr) of <= of_wdt;
    end
  end

endmodule

// File: rtl/r5p_hpm.sv
// rtl/r5p_hpm.sv - machine HPM counter bank; overflow flags and ovf_irq built only with R5P_HPM_OVF_EN
module r5p_hpm
  import r5p_hpm_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int CNT  = 29,
  parameter int CW   = 64,
  parameter int EW   = 16
) (
  input  logic          clk,
  input  logic          rst,
  r5p_hpm_if.slave      acc,
  input  logic          evt_cycle,
  input  logic          evt_instret,
  input  logic [EW-1:0] evt_i,
  output logic          ovf_irq
);

  if (CNT > 29 || CNT < 0 || EW >= XLEN || EW < 1 || CW < XLEN || CW > 64 ||
      (XLEN != 32 && XLEN != 64)) begin : g_cfg_err
    $error("r5p_hpm: unsupported parameter combination");
  end

`ifdef R5P_HPM_OVF_EN
  localparam bit OVF_BUILD = 1'b1;
`else
  localparam bit OVF_BUILD = 1'b0;
`endif

  // CY, IR and the implemented programmable counters; TM stays 0.
  localparam logic [31:0] INH_WMASK = 32'((64'd1 << (CNT + 3)) - 64'd8) | 32'h5;

  hpm_dec_t         dec;
  logic             wr;
  r5p_hpm_inhibit_t inh;
  logic [31:0]      inh_bits;
  logic [CW-1:0]    cnt_val  [HPM_NUM];
  logic [EW-1:0]    mask_val [HPM_NUM];
  logic [HPM_NUM-1:0] of_val;
  logic [XLEN-1:0]  rd;

  assign dec      = hpm_decode(acc.adr, 1'(XLEN == 32));
  assign acc.hit  = acc.en & dec.hit;
  assign acc.ill  = acc.en & acc.we & dec.hit & dec.mirror;
  assign wr       = acc.en & acc.we & dec.hit & ~dec.mirror;
  assign inh_bits = inh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               inh <= '0;
    else if (wr && dec.kind == HPM_KIND_INH) inh <= r5p_hpm_inhibit_t'(acc.wdt[31:0] & INH_WMASK);
  end

  for (genvar k = 0; k < HPM_NUM; k++) begin : g_ctr
    if (k == 0 || k == 2 || (k >= 3 && k < 3 + CNT)) begin : g_on
      logic          inc;
      logic          hit_cnt;
      logic          hit_evt;
      logic [CW-1:0] cnt;
      logic          of;

      assign hit_cnt = wr && dec.kind == HPM_KIND_CNT && dec.idx == 5'(k);
      assign hit_evt = wr && dec.kind == HPM_KIND_EVT && dec.idx == 5'(k);

      if (k >= 3) begin : g_prog
        logic [EW-1:0] mask;

        always_ff @(posedge clk or posedge rst) begin
          if (rst)          mask <= '0;
          else if (hit_evt) mask <= acc.wdt[EW-1:0];
        end

        // Any number of matching event bits still counts as a single step.
        assign inc         = (|(evt_i & mask)) & ~inh_bits[k];
        assign mask_val[k] = mask;
      end else begin : g_fixed
        assign inc         = (k == 0) ? (evt_cycle & ~inh.cy) : (evt_instret & ~inh.ir);
        assign mask_val[k] = '0;
      end

      r5p_hpm_cnt #(
        .XLEN   (XLEN),
        .CW     (CW),
        .OVF_EN (1'(OVF_BUILD && (k >= 3)))
      ) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc    (inc),
        .wr_lo  (hit_cnt & ~dec.hi),
        .wr_hi  (hit_cnt & dec.hi),
        .wdt    (acc.wdt),
        .of_wr  (hit_evt),
        .of_wdt (acc.wdt[XLEN-1]),
        .cnt    (cnt),
        .of     (of)
      );

      assign cnt_val[k] = cnt;
      assign of_val[k]  = of;
    end else begin : g_off
      assign cnt_val[k]  = '0;
      assign mask_val[k] = '0;
      assign of_val[k]   = 1'b0;
    end
  end

  // Reads see the state before any same-cycle write.
  always_comb begin
    rd = '0;
    if (acc.en && dec.hit) begin
      case (dec.kind)
        HPM_KIND_CNT: rd = XLEN'(cnt_val[dec.idx] >> (dec.hi ? XLEN : 0));
        HPM_KIND_INH: rd = XLEN'(inh_bits);
        HPM_KIND_EVT: begin
          rd           = XLEN'(mask_val[dec.idx]);
          rd[XLEN-1]   = of_val[dec.idx];
        end
        default:      rd = '0;
      endcase
    end
  end

  assign acc.rdt = rd;

`ifdef R5P_HPM_OVF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_irq <= 1'b0;
    else     ovf_irq <= |(of_val & ~inh_bits);
  end
`else
  assign ovf_irq = 1'b0;
`endif

endmodule

// File: tb/tb_r5p_hpm.sv
// tb/tb_r5p_hpm.sv - self-checking bench for r5p_hpm (XLEN=32, CNT=4, CW=64, EW=16)
module tb_r5p_hpm;

  localparam int XLEN = 32;
  localparam int CNT  = 4;
  localparam int CW   = 64;
  localparam int EW   = 16;

`ifdef R5P_HPM_OVF_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif
  localparam logic [31:0] OFB = OVF ? 32'h8000_0000 : 32'h0;

  logic          clk = 1'b0;
  logic          rst;
  logic          evt_cycle;
  logic          evt_instret;
  logic [EW-1:0] evt_i;
  logic          ovf_irq;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [$];

  r5p_hpm_if #(.XLEN(XLEN)) acc_bus ();

  r5p_hpm #(
    .XLEN (XLEN),
    .CNT  (CNT),
    .CW   (CW),
    .EW   (EW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .acc         (acc_bus),
    .evt_cycle   (evt_cycle),
    .evt_instret (evt_instret),
    .evt_i       (evt_i),
    .ovf_irq     (ovf_irq)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_wr(input logic [11:0] adr, input logic [31:0] wdt);
    acc_bus.en  = 1'b1;
    acc_bus.we  = 1'b1;
    acc_bus.adr = adr;
    acc_bus.wdt = wdt;
    step();
    acc_bus.en  = 1'b0;
    acc_bus.we  = 1'b0;
  endtask

  task automatic csr_rd(input string tag, input logic [11:0] adr, input logic [31:0] exp);
    acc_bus.en  = 1'b1;
    acc_bus.we  = 1'b0;
    acc_bus.adr = adr;
    exp_q.push_back(exp);
    @(negedge clk);
    if (exp_q.size() == 0) check_val({tag, "_sb_empty"}, 32'd0, 32'd1);
    else                   check_val(tag, acc_bus.rdt, exp_q.pop_front());
    step();
    acc_bus.en = 1'b0;
  endtask

  task automatic chk_irq(input string tag, input logic exp);
    @(negedge clk);
    check_val(tag, 32'(ovf_irq), 32'(exp));
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; evt_cycle = 1'b0; evt_instret = 1'b0; evt_i = '0;
    acc_bus.en = 1'b0; acc_bus.we = 1'b0; acc_bus.adr = '0; acc_bus.wdt = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    @(negedge clk);
    check_val("rst_irq", 32'(ovf_irq), 32'd0);
    check_val("rst_hit", 32'(acc_bus.hit), 32'd0);
    check_val("rst_rdt", acc_bus.rdt, 32'd0);
    step();
    csr_rd("rst_mcycle", 12'hB00, 32'd0);
    csr_rd("rst_mhpmevent3", 12'h323, 32'd0);

    // basic cycle / instret counting
    evt_cycle = 1'b1;
    repeat (10) step();
    evt_cycle = 1'b0;
    csr_rd("mcycle_10", 12'hB00, 32'd10);
    csr_rd("minstret_0", 12'hB02, 32'd0);
    repeat (3) begin
      evt_instret = 1'b1; step();
      evt_instret = 1'b0; step();
    end
    csr_rd("minstret_3", 12'hB02, 32'd3);

    // inhibit freezes, writable bits, then resume
    csr_wr(12'h320, 32'h1);
    evt_cycle = 1'b1;
    repeat (5) step();
    evt_cycle = 1'b0;
    csr_rd("mcycle_frozen", 12'hB00, 32'd10);
    csr_wr(12'h320, 32'hFFFF_FFFF);
    csr_rd("inhibit_mask", 12'h320, 32'h0000_007D);
    csr_wr(12'h320, 32'h0);
    evt_cycle = 1'b1;
    csr_rd("mcycle_run0", 12'hB00, 32'd10);
    csr_rd("mcycle_run1", 12'hB00, 32'd11);
    csr_rd("mcycle_run2", 12'hB00, 32'd12);
    evt_cycle = 1'b0;
    csr_rd("mcycle_run3", 12'hB00, 32'd13);

    // split halves and carry into the high word
    csr_wr(12'hB83, 32'h0000_0001);
    csr_wr(12'hB03, 32'hFFFF_FFFF);
    csr_wr(12'h323, 32'h4);
    evt_i = 16'h0004; step(); evt_i = '0;
    csr_rd("split_lo", 12'hB03, 32'h0);
    csr_rd("split_hi", 12'hB83, 32'h2);
    csr_rd("split_evt", 12'h323, 32'h4);
    csr_rd("mirror_hi", 12'hC83, 32'h2);

    // overflow wrap, OF flag and interrupt timing
    evt_i = 16'h0004;
    csr_wr(12'hB83, 32'hFFFF_FFFF);
    csr_wr(12'hB03, 32'hFFFF_FFFF);
    csr_rd("ovf_allones", 12'hB03, 32'hFFFF_FFFF);
    evt_i = '0;
    chk_irq("irq_lag", 1'b0);
    chk_irq("irq_set", OVF);
    csr_rd("ovf_wrap_lo", 12'hB03, 32'h0);
    csr_rd("ovf_wrap_hi", 12'hB83, 32'h0);
    csr_rd("ovf_of_set", 12'h323, OFB | 32'h4);
    csr_wr(12'h323, 32'h4);
    chk_irq("irq_hold", OVF);
    chk_irq("irq_clr", 1'b0);
    csr_rd("ovf_of_clr", 12'h323, 32'h4);

    // wrap beats a clearing write on the same edge
    evt_i = 16'h0004;
    csr_wr(12'hB83, 32'hFFFF_FFFF);
    csr_wr(12'hB03, 32'hFFFF_FFFF);
    csr_wr(12'h323, 32'h4);
    evt_i = '0;
    csr_rd("of_priority", 12'h323, OFB | 32'h4);
    csr_wr(12'h323, 32'h0);

    // write beats increment; multi-bit event still steps by one
    csr_wr(12'h325, 32'h1);
    evt_i = 16'h0001;
    csr_wr(12'hB05, 32'h0000_1234);
    evt_i = '0;
    csr_rd("wr_beats_inc", 12'hB05, 32'h0000_1234);
    csr_rd("wr_beats_inc_hi", 12'hB85, 32'h0);
    csr_wr(12'h326, 32'h3);
    evt_i = 16'h0003; step(); evt_i = '0;
    csr_rd("multi_bit_step", 12'hB06, 32'h1);

    // unimplemented counter, unmapped address, mirror write
    csr_wr(12'hB0A, 32'h5);
    acc_bus.en = 1'b1; acc_bus.we = 1'b0; acc_bus.adr = 12'hB0A;
    @(negedge clk);
    check_val("unimpl_hit", 32'(acc_bus.hit), 32'd1);
    check_val("unimpl_rdt", acc_bus.rdt, 32'd0);
    acc_bus.adr = 12'hB01;
    #1 check_val("time_nohit", 32'(acc_bus.hit), 32'd0);
    step();
    acc_bus.en = 1'b0;
    acc_bus.en = 1'b1; acc_bus.we = 1'b1; acc_bus.adr = 12'hC00; acc_bus.wdt = 32'h0000_DEAD;
    @(negedge clk);
    check_val("mirror_ill", 32'(acc_bus.ill), 32'd1);
    step();
    acc_bus.en = 1'b0; acc_bus.we = 1'b0;
    @(negedge clk);
    check_val("idle_ill", 32'(acc_bus.ill), 32'd0);
    check_val("idle_hit", 32'(acc_bus.hit), 32'd0);
    step();
    csr_rd("mirror_keep", 12'hC00, 32'd13);
    csr_rd("mirror_instret", 12'hC02, 32'd3);

    // asynchronous reset mid-count
    evt_cycle = 1'b1;
    repeat (4) step();
    acc_bus.en = 1'b1; acc_bus.we = 1'b0; acc_bus.adr = 12'hB00;
    #1 check_val("pre_rst", acc_bus.rdt, 32'd17);
    #1 rst = 1'b1;
    #1 check_val("async_rst", acc_bus.rdt, 32'd0);
    evt_cycle = 1'b0;
    acc_bus.en = 1'b0;
    step();
    rst = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
